// File: rtl/mem_lsu.sv
// Memory-access stage: one data-bus request/response per memory op, load extension, pipeline stall.
// Build macro MEM_LSU_ALIGN_CHECK_EN: misaligned half/word ops skip the bus and raise ale_out.
module mem_lsu #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              cpu_clk,
  input  logic              cpu_rstn,
  input  logic              valid_in,
  input  logic [3:0]        mem_op,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [DATA_W-1:0] wdata_in,
  output logic              mem_stall,
  output logic [DATA_W-1:0] ram_ext_out,
  output logic              data_req,
  output logic              data_we,
  output logic [ADDR_W-1:0] data_addr,
  output logic [3:0]        data_wstrb,
  output logic [DATA_W-1:0] data_wdata,
  input  logic              data_addr_ok,
  input  logic              data_ok,
  input  logic [DATA_W-1:0] data_rdata,
  output logic              ale_out
);

  localparam logic [3:0] OP_LB  = 4'd1;
  localparam logic [3:0] OP_LH  = 4'd2;
  localparam logic [3:0] OP_LW  = 4'd3;
  localparam logic [3:0] OP_LBU = 4'd4;
  localparam logic [3:0] OP_LHU = 4'd5;
  localparam logic [3:0] OP_SB  = 4'd6;
  localparam logic [3:0] OP_SH  = 4'd7;
  localparam logic [3:0] OP_SW  = 4'd8;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t      state, state_nx;
  logic        is_mem, is_store, misalign, capture;
  logic [3:0]  op_p0;
  logic [1:0]  off_p0;

  function automatic logic [3:0] lane_strb(input logic [3:0] op, input logic [1:0] off);
    case (op)
      OP_SB:   lane_strb = 4'b0001 << off;
      OP_SH:   lane_strb = off[1] ? 4'b1100 : 4'b0011;
      OP_SW:   lane_strb = 4'b1111;
      default: lane_strb = 4'b0000;
    endcase
  endfunction

  function automatic logic [DATA_W-1:0] lane_wdata(input logic [3:0] op, input logic [DATA_W-1:0] wd);
    case (op)
      OP_SB:   lane_wdata = {(DATA_W/8){wd[7:0]}};
      OP_SH:   lane_wdata = {(DATA_W/16){wd[15:0]}};
      OP_SW:   lane_wdata = wd;
      default: lane_wdata = '0;
    endcase
  endfunction

  function automatic logic [DATA_W-1:0] ext_load(input logic [3:0] op, input logic [1:0] off,
                                                 input logic [DATA_W-1:0] rd);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(rd >> {off, 3'b000});
    h = 16'(rd >> {off[1], 4'b0000});
    case (op)
      OP_LB:   ext_load = {{(DATA_W-8){b[7]}}, b};
      OP_LBU:  ext_load = {{(DATA_W-8){1'b0}}, b};
      OP_LH:   ext_load = {{(DATA_W-16){h[15]}}, h};
      OP_LHU:  ext_load = {{(DATA_W-16){1'b0}}, h};
      OP_LW:   ext_load = rd;
      default: ext_load = '0;
    endcase
  endfunction

  assign is_mem   = valid_in && (mem_op >= OP_LB) && (mem_op <= OP_SW);
  assign is_store = (mem_op >= OP_SB) && (mem_op <= OP_SW);

`ifdef MEM_LSU_ALIGN_CHECK_EN
  assign misalign = ((mem_op == OP_LH || mem_op == OP_LHU || mem_op == OP_SH) && addr_in[0]) ||
                    ((mem_op == OP_LW || mem_op == OP_SW) && (addr_in[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn) state <= IDLE;
    else           state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (is_mem) state_nx = misalign ? DONE : REQ;
      REQ:  if (data_addr_ok) state_nx = data_ok ? DONE : WAIT;
      WAIT: if (data_ok) state_nx = DONE;
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    data_req  = (state == REQ);
    mem_stall = is_mem && (state != DONE);
  end

  // Response beat: either addr_ok+data_ok together in REQ, or data_ok in WAIT
  assign capture = ((state == REQ) && data_addr_ok && data_ok) || ((state == WAIT) && data_ok);

  always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn) begin
      data_addr   <= '0;
      data_we     <= 1'b0;
      data_wstrb  <= 4'b0000;
      data_wdata  <= '0;
      op_p0       <= 4'd0;
      off_p0      <= 2'b00;
      ram_ext_out <= '0;
    end else begin
      if (state == IDLE && is_mem) begin
        data_addr  <= {addr_in[ADDR_W-1:2], 2'b00};
        data_we    <= is_store;
        data_wstrb <= lane_strb(mem_op, addr_in[1:0]);
        data_wdata <= lane_wdata(mem_op, wdata_in);
        op_p0      <= mem_op;
        off_p0     <= addr_in[1:0];
      end
      ram_ext_out <= capture ? ext_load(op_p0, off_p0, data_rdata) : '0;
    end
  end

`ifdef MEM_LSU_ALIGN_CHECK_EN
  always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn) ale_out <= 1'b0;
    else           ale_out <= (state == IDLE) && is_mem && misalign;
  end
`else
  assign ale_out = 1'b0;
`endif

endmodule

// File: tb/tb_mem_lsu.sv
// Bench for mem_lsu: directed cases plus randomized transactions against a behavioural model.
module tb_mem_lsu;

  localparam logic [3:0] OP_LB  = 4'd1;
  localparam logic [3:0] OP_LH  = 4'd2;
  localparam logic [3:0] OP_LW  = 4'd3;
  localparam logic [3:0] OP_LBU = 4'd4;
  localparam logic [3:0] OP_LHU = 4'd5;
  localparam logic [3:0] OP_SB  = 4'd6;
  localparam logic [3:0] OP_SH  = 4'd7;
  localparam logic [3:0] OP_SW  = 4'd8;

  logic        cpu_clk, cpu_rstn, valid_in;
  logic [3:0]  mem_op;
  logic [31:0] addr_in, wdata_in;
  logic        mem_stall;
  logic [31:0] ram_ext_out;
  logic        data_req, data_we;
  logic [31:0] data_addr;
  logic [3:0]  data_wstrb;
  logic [31:0] data_wdata;
  logic        data_addr_ok, data_ok;
  logic [31:0] data_rdata;
  logic        ale_out;

  int n_checks = 0;
  int n_errors = 0;

  mem_lsu #(.ADDR_W(32), .DATA_W(32)) dut (
    .cpu_clk(cpu_clk), .cpu_rstn(cpu_rstn), .valid_in(valid_in), .mem_op(mem_op),
    .addr_in(addr_in), .wdata_in(wdata_in), .mem_stall(mem_stall), .ram_ext_out(ram_ext_out),
    .data_req(data_req), .data_we(data_we), .data_addr(data_addr), .data_wstrb(data_wstrb),
    .data_wdata(data_wdata), .data_addr_ok(data_addr_ok), .data_ok(data_ok),
    .data_rdata(data_rdata), .ale_out(ale_out)
  );

  initial cpu_clk = 1'b0;
  always #5 cpu_clk = ~cpu_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic ref_misalign(input logic [3:0] op, input logic [31:0] a);
    bit en;
`ifdef MEM_LSU_ALIGN_CHECK_EN
    en = 1'b1;
`else
    en = 1'b0;
`endif
    return en && ((((op == OP_LH) || (op == OP_LHU) || (op == OP_SH)) && (a % 2 != 0)) ||
                  (((op == OP_LW) || (op == OP_SW)) && (a % 4 != 0)));
  endfunction

  function automatic logic [31:0] ref_load(input logic [3:0] op, input logic [31:0] a, input logic [31:0] rd);
    longint v;
    case (op)
      OP_LB, OP_LBU: begin
        v = longint'((rd >> (8 * a[1:0])) & 32'hFF);
        if (op == OP_LB && v >= 128) v = v - 256;
      end
      OP_LH, OP_LHU: begin
        v = longint'((rd >> (16 * a[1])) & 32'hFFFF);
        if (op == OP_LH && v >= 32768) v = v - 65536;
      end
      OP_LW:   v = longint'(rd);
      default: v = 0;
    endcase
    return v[31:0];
  endfunction

  function automatic logic [3:0] ref_strb(input logic [3:0] op, input logic [31:0] a);
    case (op)
      OP_SB:   return 4'(1 << a[1:0]);
      OP_SH:   return 4'(3 << (2 * a[1]));
      OP_SW:   return 4'hF;
      default: return 4'h0;
    endcase
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [3:0] op, input logic [31:0] wd);
    case (op)
      OP_SB:   return 32'(wd[7:0]) * 32'h0101_0101;
      OP_SH:   return 32'(wd[15:0]) * 32'h0001_0001;
      default: return wd;
    endcase
  endfunction

  // Called at posedge+1 with the DUT idle; returns at posedge+1 of the cycle after DONE.
  task automatic run_txn(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [31:0] rd, input int ad, input int dd, input bit spur);
    logic mis, e_we;
    logic [31:0] e_ext, e_wd;
    logic [3:0] e_strb;
    int e_stalls, e_reqs, stalls, reqs, waitc;
    bit accepted, done;
    mis      = ref_misalign(op, addr);
    e_we     = (op >= OP_SB);
    e_strb   = ref_strb(op, addr);
    e_wd     = ref_wdata(op, wd);
    e_ext    = mis ? 32'h0 : ref_load(op, addr, rd);
    e_stalls = mis ? 1 : 2 + ad + dd;
    e_reqs   = mis ? 0 : ad + 1;
    valid_in = 1'b1; mem_op = op; addr_in = addr; wdata_in = wd;
    stalls = 0; reqs = 0; waitc = 0; accepted = 0; done = 0;
    for (int cyc = 0; cyc < 64 && !done; cyc++) begin
      data_addr_ok = 1'b0;
      data_ok = 1'b0;
      if (data_req) begin
        reqs++;
        chk("req_addr", data_addr, addr & ~32'h3);
        chk("req_we", 32'(data_we), 32'(e_we));
        chk("req_strb", 32'(data_wstrb), 32'(e_strb));
        if (e_we) chk("req_wdata", data_wdata, e_wd);
        if (reqs > ad) begin
          data_addr_ok = 1'b1;
          accepted = 1'b1;
          data_ok = (dd == 0);
        end else if (spur) data_ok = 1'($urandom_range(0, 1));
      end else if (accepted) begin
        waitc++;
        data_ok = (waitc == dd);
      end else if (spur) data_ok = 1'($urandom_range(0, 1));
      data_rdata = (data_ok && accepted) ? rd : $urandom;
      #1;
      if (mem_stall) begin
        stalls++;
        chk("ext_in_stall", ram_ext_out, 32'h0);
      end else begin
        done = 1'b1;
        chk("ext_done", ram_ext_out, e_ext);
        chk("ale_done", 32'(ale_out), 32'(mis));
      end
      @(posedge cpu_clk); #1;
    end
    data_addr_ok = 1'b0;
    data_ok = 1'b0;
    chk("txn_done", 32'(done), 32'd1);
    chk("stall_cycles", 32'(stalls), 32'(e_stalls));
    chk("req_cycles", 32'(reqs), 32'(e_reqs));
  endtask

  task automatic idle_cycle(input logic v, input logic [3:0] op);
    valid_in = v; mem_op = op; addr_in = $urandom;
    data_addr_ok = 1'b0; data_ok = 1'b0;
    #1;
    chk("nm_stall", 32'(mem_stall), 32'd0);
    chk("nm_req", 32'(data_req), 32'd0);
    chk("nm_ext", ram_ext_out, 32'h0);
    @(posedge cpu_clk); #1;
  endtask

  initial begin
    logic [3:0] rop;
    int k;
    cpu_rstn = 1'b0; valid_in = 1'b0; mem_op = 4'd0; addr_in = '0; wdata_in = '0;
    data_addr_ok = 1'b0; data_ok = 1'b0; data_rdata = '0;
    repeat (2) @(posedge cpu_clk);
    #1;
    chk("rst_req", 32'(data_req), 32'd0);
    chk("rst_we", 32'(data_we), 32'd0);
    chk("rst_strb", 32'(data_wstrb), 32'd0);
    chk("rst_stall", 32'(mem_stall), 32'd0);
    chk("rst_ale", 32'(ale_out), 32'd0);
    chk("rst_addr", data_addr, 32'h0);
    chk("rst_wdata", data_wdata, 32'h0);
    chk("rst_ext", ram_ext_out, 32'h0);
    cpu_rstn = 1'b1;
    @(posedge cpu_clk); #1;

    run_txn(OP_LB, 32'h0000_1003, 32'h0, 32'h80FF_1234, 0, 0, 1'b0);
    run_txn(OP_LHU, 32'h0000_2002, 32'h0, 32'h8001_7FFF, 2, 3, 1'b0);
    run_txn(OP_SB, 32'h0000_3001, 32'h0000_00AB, 32'h0, 0, 1, 1'b0);
    idle_cycle(1'b1, 4'd0);
    run_txn(OP_SW, 32'h0000_4000, 32'hDEAD_BEEF, 32'h0, 1, 0, 1'b0);
    run_txn(OP_LW, 32'h0000_4000, 32'h0, 32'hDEAD_BEEF, 0, 2, 1'b0);
    run_txn(OP_LW, 32'h0000_5002, 32'h0, 32'h1357_9BDF, 0, 0, 1'b0);
    run_txn(OP_LH, 32'h0000_6002, 32'h0, 32'h8000_0001, 0, 0, 1'b1);
    idle_cycle(1'b0, OP_LW);
    idle_cycle(1'b1, 4'd12);

    // Reset while waiting for the read response
    valid_in = 1'b1; mem_op = OP_LW; addr_in = 32'h0000_7000;
    #1; @(posedge cpu_clk); #1;
    data_addr_ok = 1'b1;
    @(posedge cpu_clk); #1;
    data_addr_ok = 1'b0;
    chk("wait_req", 32'(data_req), 32'd0);
    chk("wait_stall", 32'(mem_stall), 32'd1);
    cpu_rstn = 1'b0;
    #1;
    chk("rstw_req", 32'(data_req), 32'd0);
    chk("rstw_stall_mem", 32'(mem_stall), 32'd1);
    chk("rstw_ext", ram_ext_out, 32'h0);
    valid_in = 1'b0;
    #1;
    chk("rstw_stall_nomem", 32'(mem_stall), 32'd0);
    @(posedge cpu_clk); #1;
    cpu_rstn = 1'b1;
    run_txn(OP_LW, 32'h0000_7004, 32'h0, 32'hCAFE_F00D, 1, 1, 1'b0);

    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        k = $urandom_range(0, 7);
        rop = (k == 0) ? 4'd0 : 4'(8 + k);
        idle_cycle(1'($urandom_range(0, 1)), rop);
      end
      run_txn(4'($urandom_range(1, 8)), $urandom, $urandom, $urandom,
              $urandom_range(0, 3), $urandom_range(0, 3), 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
